// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding, and aborts accesses
// that never see an ack within TIMEOUT cycles.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regWrite_in,
    input  logic [1:0]  resultSrc_in,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic [15:0] pc_plus2_in,
    input  logic [3:0]  rd_in,
    input  logic [15:0] aluRes_in,
    input  logic [15:0] writeData_in,
    output logic        regWrite_out,
    output logic [1:0]  resultSrc_out,
    output logic [15:0] pc_plus2_out,
    output logic [3:0]  rd_out,
    output logic [15:0] aluRes_out,
    output logic [15:0] readData_out,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] count;
    logic       aborted;
    logic       abort_now;
    logic       memop;
    logic       expire;

    assign memop  = memRead_in | memWrite_in;
    assign expire = (count == LAST_COUNT);

    assign resultSrc_out = resultSrc_in;
    assign pc_plus2_out  = pc_plus2_in;
    assign rd_out        = rd_in;
    assign aluRes_out    = aluRes_in;
    assign regWrite_out  = regWrite_in & ~stall & ~abort_now;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus stall and abort qualification of the writeback.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        abort_now  = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    stall      = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_ack || expire) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                abort_now  = aborted;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus request, watchdog counter, load data and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 16'h0000;
            mem_wdata    <= 16'h0000;
            readData_out <= 16'h0000;
            bus_err      <= 1'b0;
            count        <= 8'd0;
            aborted      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        mem_req   <= 1'b1;
                        mem_we    <= memWrite_in;
                        mem_addr  <= aluRes_in;
                        mem_wdata <= writeData_in;
                        count     <= 8'd0;
                        aborted   <= 1'b0;
                    end
                end
                WAIT: begin
                    count <= count + 8'd1;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        aborted <= 1'b0;
                        if (!mem_we) begin
                            readData_out <= mem_rdata;
                        end
                    end else if (expire) begin
                        mem_req      <= 1'b0;
                        readData_out <= 16'h0000;
                        bus_err      <= 1'b1;
                        aborted      <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: pass-through vector table plus a
// scoreboard of expected writeback results for each memory access.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        regWrite_in;
    logic [1:0]  resultSrc_in;
    logic        memRead_in;
    logic        memWrite_in;
    logic [15:0] pc_plus2_in;
    logic [3:0]  rd_in;
    logic [15:0] aluRes_in;
    logic [15:0] writeData_in;
    logic        regWrite_out;
    logic [1:0]  resultSrc_out;
    logic [15:0] pc_plus2_out;
    logic [3:0]  rd_out;
    logic [15:0] aluRes_out;
    logic [15:0] readData_out;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic [15:0] pc;
        logic [3:0]  rd;
        logic [15:0] alu;
        logic        expRegWrite;
        logic [1:0]  expResultSrc;
        logic [15:0] expPc;
        logic [3:0]  expRd;
        logic [15:0] expAlu;
    } aluVec_t;

    typedef struct {
        logic [15:0] readData;
        logic        regWrite;
        logic        busErr;
        int          stallCycles;
    } expect_t;

    aluVec_t     vecs[4];
    expect_t     scoreboard[$];
    logic [15:0] modelRead;
    logic        modelBusErr;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .regWrite_in(regWrite_in), .resultSrc_in(resultSrc_in),
        .memRead_in(memRead_in), .memWrite_in(memWrite_in),
        .pc_plus2_in(pc_plus2_in), .rd_in(rd_in),
        .aluRes_in(aluRes_in), .writeData_in(writeData_in),
        .regWrite_out(regWrite_out), .resultSrc_out(resultSrc_out),
        .pc_plus2_out(pc_plus2_out), .rd_out(rd_out),
        .aluRes_out(aluRes_out), .readData_out(readData_out),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        regWrite_in  = 1'b0;
        resultSrc_in = 2'd0;
        memRead_in   = 1'b0;
        memWrite_in  = 1'b0;
        pc_plus2_in  = 16'h0000;
        rd_in        = 4'd0;
        aluRes_in    = 16'h0000;
        writeData_in = 16'h0000;
        mem_ack      = 1'b0;
        mem_rdata    = 16'h0000;
    endtask

    // One memory op; ackAt is the 0-based WAIT cycle of the ack, or -1 for none.
    task automatic applyStimulus(input logic isStore, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [3:0] rd,
                                 input int ackAt, input logic [15:0] rdata);
        expect_t exp;
        expect_t got;
        int      stallCount;
        bit      done;
        bit      acked;
        stallCount = 0;
        done       = 1'b0;
        acked      = (ackAt >= 0) && (ackAt < TO);
        @(posedge clk); #1;
        regWrite_in  = ~isStore;
        resultSrc_in = 2'd1;
        memRead_in   = ~isStore;
        memWrite_in  = isStore;
        pc_plus2_in  = 16'h0102;
        rd_in        = rd;
        aluRes_in    = addr;
        writeData_in = wdata;
        if (!acked) begin
            modelRead   = 16'h0000;
            modelBusErr = 1'b1;
        end else if (!isStore) begin
            modelRead = rdata;
        end
        exp.readData    = modelRead;
        exp.regWrite    = acked ? ~isStore : 1'b0;
        exp.busErr      = modelBusErr;
        exp.stallCycles = acked ? ackAt + 2 : TO + 1;
        scoreboard.push_back(exp);
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                mem_ack   = (cyc - 1 == ackAt);
                mem_rdata = rdata;
            end
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stallCount++;
            checkOutput("bubble_regWrite", 32'(regWrite_out), 32'd0);
            if (cyc == 0) begin
                checkOutput("req_low_in_idle", 32'(mem_req), 32'd0);
            end else begin
                checkOutput("req_held", 32'(mem_req), 32'd1);
                checkOutput("we_held", 32'(mem_we), 32'(isStore));
                checkOutput("addr_held", 32'(mem_addr), 32'(addr));
                if (isStore) checkOutput("wdata_held", 32'(mem_wdata), 32'(wdata));
            end
        end
        mem_ack = 1'b0;
        if (!done) begin
            checkOutput("done_within_budget", 32'd0, 32'd1);
        end else begin
            got = scoreboard.pop_front();
            checkOutput("done_readData", 32'(readData_out), 32'(got.readData));
            checkOutput("done_regWrite", 32'(regWrite_out), 32'(got.regWrite));
            checkOutput("done_bus_err", 32'(bus_err), 32'(got.busErr));
            checkOutput("done_req_low", 32'(mem_req), 32'd0);
            checkOutput("stall_cycles", 32'(stallCount), 32'(got.stallCycles));
        end
        @(posedge clk); #1;
        driveIdle();
        @(negedge clk);
        checkOutput("idle_after_done_stall", 32'(stall), 32'd0);
        checkOutput("idle_after_done_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd0, 16'h0010, 4'd5, 16'h1234, 1'b1, 2'd0, 16'h0010, 4'd5, 16'h1234};
        vecs[1] = '{1'b0, 2'd2, 16'h0FFE, 4'd15, 16'hFFFF, 1'b0, 2'd2, 16'h0FFE, 4'd15, 16'hFFFF};
        vecs[2] = '{1'b1, 2'd3, 16'h8000, 4'd1, 16'h0000, 1'b1, 2'd3, 16'h8000, 4'd1, 16'h0000};
        vecs[3] = '{1'b1, 2'd1, 16'hABCD, 4'd9, 16'h5A5A, 1'b1, 2'd1, 16'hABCD, 4'd9, 16'h5A5A};
        modelRead   = 16'h0000;
        modelBusErr = 1'b0;
        reset = 1'b0;
        driveIdle();
        #2;
        checkOutput("reset_req", 32'(mem_req), 32'd0);
        checkOutput("reset_bus_err", 32'(bus_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_stall", 32'(stall), 32'd0);
        checkOutput("post_reset_we", 32'(mem_we), 32'd0);
        checkOutput("post_reset_addr", 32'(mem_addr), 32'd0);
        checkOutput("post_reset_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("post_reset_rdata", 32'(readData_out), 32'd0);

        // Non-memory instructions; a stray ack must be ignored.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            regWrite_in  = vecs[i].regWrite;
            resultSrc_in = vecs[i].resultSrc;
            pc_plus2_in  = vecs[i].pc;
            rd_in        = vecs[i].rd;
            aluRes_in    = vecs[i].alu;
            mem_ack      = (i == 1);
            mem_rdata    = 16'hFFFF;
            @(negedge clk);
            checkOutput("alu_regWrite", 32'(regWrite_out), 32'(vecs[i].expRegWrite));
            checkOutput("alu_resultSrc", 32'(resultSrc_out), 32'(vecs[i].expResultSrc));
            checkOutput("alu_pc", 32'(pc_plus2_out), 32'(vecs[i].expPc));
            checkOutput("alu_rd", 32'(rd_out), 32'(vecs[i].expRd));
            checkOutput("alu_res", 32'(aluRes_out), 32'(vecs[i].expAlu));
            checkOutput("alu_stall", 32'(stall), 32'd0);
            checkOutput("alu_req", 32'(mem_req), 32'd0);
            checkOutput("alu_rdata_untouched", 32'(readData_out), 32'd0);
        end
        @(posedge clk); #1;
        driveIdle();

        applyStimulus(1'b0, 16'h0040, 16'h0000, 4'd3, 0, 16'hBEEF);
        applyStimulus(1'b1, 16'h0080, 16'hA5A5, 4'd0, 3, 16'h7777);
        applyStimulus(1'b0, 16'h00C0, 16'h0000, 4'd4, -1, 16'h0000);
        applyStimulus(1'b0, 16'h00C2, 16'h0000, 4'd6, TO - 1, 16'h4321);

        // Reset in the middle of a load's WAIT phase.
        @(posedge clk); #1;
        regWrite_in = 1'b1;
        memRead_in  = 1'b1;
        rd_in       = 4'd7;
        aluRes_in   = 16'h0100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("midwait_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        driveIdle();
        #1;
        checkOutput("async_reset_req", 32'(mem_req), 32'd0);
        checkOutput("async_reset_bus_err", 32'(bus_err), 32'd0);
        checkOutput("async_reset_addr", 32'(mem_addr), 32'd0);
        checkOutput("async_reset_rdata", 32'(readData_out), 32'd0);
        checkOutput("async_reset_stall", 32'(stall), 32'd0);
        modelRead   = 16'h0000;
        modelBusErr = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(1'b0, 16'h0200, 16'h0000, 4'd8, 2, 16'h1357);

        checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 16-bit pipeline, between the EX/MEM register and the MEM/WB register. It runs loads and stores against data memory over a req/ack handshake. It stalls the upstream stages while an access is outstanding and presents either a completed instruction or a bubble to MEM/WB on every cycle. MEM/WB has no enable, so this block must hold back the write-enable itself whenever it is not presenting a finished instruction. A watchdog counter aborts accesses that never receive an ack.

## Interface
- TIMEOUT, 16: maximum cycles spent in WAIT before an access is aborted; legal range 1..255.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- regWrite_in  in  1  register-write enable from EX/MEM.
- resultSrc_in  in  2  writeback mux select from EX/MEM.
- memRead_in  in  1  instruction is a load.
- memWrite_in  in  1  instruction is a store.
- pc_plus2_in  in  16  PC+2 of the instruction.
- rd_in  in  4  destination register.
- aluRes_in  in  16  ALU result; also the memory address.
- writeData_in  in  16  store data.
- regWrite_out  out  1  to MEM/WB; equals regWrite_in & ~stall & ~abort_now.
- resultSrc_out, pc_plus2_out, rd_out, aluRes_out  out  2/16/4/16  combinational pass-through to MEM/WB.
- readData_out  out  16  registered load data to MEM/WB.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- mem_req  out  1  registered bus request.
- mem_we  out  1  registered; 1 = write.
- mem_addr  out  16  registered address.
- mem_wdata  out  16  registered write data.
- mem_rdata  in  16  read data; valid in any cycle where mem_ack=1.
- mem_ack  in  1  single-cycle completion strobe.
- bus_err  out  1  sticky flag: some access has timed out; cleared only by reset.

## Operation
- The block is a three-state FSM: IDLE, WAIT, DONE.
- A memory op is present when memop = memRead_in | memWrite_in.
- IDLE, memop=0:
  - Pass-through; stall=0.
  - Stay in IDLE.
- IDLE, memop=1:
  - stall=1.
  - On the clock edge, latch mem_addr←aluRes_in, mem_wdata←writeData_in, mem_we←memWrite_in.
  - Set mem_req←1, clear the timeout counter, go to WAIT.
  - If memRead and memWrite are both set, the op is treated as a store.
- WAIT:
  - stall=1; mem_req, mem_we, mem_addr and mem_wdata held stable.
  - The counter increments every cycle.
  - If mem_ack=1: readData_out←mem_rdata (store: readData_out unchanged), mem_req←0, go to DONE as a completed access.
  - Else if the counter = TIMEOUT-1: mem_req←0, readData_out←0, bus_err←1, go to DONE flagged as aborted.
  - If ack arrives in the same cycle as expiry, ack wins.
- DONE:
  - stall=0, so EX/MEM advances and MEM/WB captures the instruction on this edge.
  - regWrite_out = regWrite_in if the access completed, 0 if it was aborted.
  - Go to IDLE unconditionally. The next instruction is evaluated in IDLE on the following cycle.
- mem_ack outside WAIT is ignored.
- Whenever stall=1, regWrite_out=0, so MEM/WB receives a bubble. All other pass-through fields are don't-care at those times.

## Timing
- Reset asserted (asynchronous) drives all of the following immediately, whatever the current state, including mid-WAIT:
  - state=IDLE, mem_req=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, readData_out=0.
  - bus_err=0, counter=0.
- Non-memory instruction: zero added latency; outputs are combinational from the inputs in the same cycle.
- Memory op with ack in the first WAIT cycle: 3 cycles in this stage, with stall=1 for 2 cycles.
- Ack in WAIT cycle k (k = 0-based): stall lasts k+2 cycles.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then 1 DONE cycle.
- mem_req rises on the edge leaving IDLE and falls on the edge leaving WAIT.
- Back-to-back memory ops: the second op is seen in IDLE the cycle after DONE. mem_req is therefore low for at least 2 cycles between requests.

## Test plan
- Reset low, then high with inputs idle -> all registered outputs 0, stall=0, bus_err=0.
- ALU op: regWrite_in=1, rd_in=5, aluRes_in=0x1234, memop=0 -> same cycle regWrite_out=1, rd_out=5, aluRes_out=0x1234, stall=0, mem_req stays 0.
- Load addr 0x0040, ack in first WAIT cycle with rdata=0xBEEF ->
  - stall=1 for 2 cycles, mem_addr=0x0040, mem_we=0.
  - DONE cycle: readData_out=0xBEEF, regWrite_out=1.
- Store addr 0x0080 data 0xA5A5, ack delayed to WAIT cycle 3 ->
  - mem_we=1 and mem_addr/mem_wdata stable for 4 WAIT cycles.
  - stall high 5 cycles, readData_out unchanged.
- TIMEOUT=4, load with no ack ->
  - mem_req=0 after 4 WAIT cycles, bus_err=1.
  - DONE cycle: regWrite_out=0, readData_out=0.
  - A following load acked normally completes; bus_err remains 1.
- Reset pulled low during WAIT of a load -> mem_req=0 before the next clock edge, state=IDLE, bus_err=0. After release, a new load completes normally.
